// File: rtl/nmos_cmp_counter.sv
// nmos_cmp_counter: value generator for the VV inputs of a chain of two-phase
// comparator bit cells. A WIDTH-bit up-counter runs against a limit that is
// loaded from the data bus through a two-stage LD/C1 latch pair, and a
// registered terminal-count strobe (TC) fires when the count matches the limit.
//
// Optional feature macro: NMOS_CMP_CNT_PRESCALE_EN
//   Defined   : an internal prescaler divides CE so that only every PRESCALE-th
//               CE tick in RUN acts as a count step.
//   Undefined : every CE is a count step; PRESCALE is only range-checked.

module nmos_cmp_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             main_clk,
    input  logic             main_rst,
    input  logic [WIDTH-1:0] DB,
    input  logic             LD,
    input  logic             C1,
    input  logic             CE,
    input  logic             START,
    input  logic             STOP,
    input  logic             ONESHOT,
    output logic [WIDTH-1:0] VV,
    output logic             TC,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] vv_q, vv_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    // Qualified count step: CE, optionally divided by the prescaler.
    logic             step;

    // Reject an out-of-range divide ratio at elaboration time.
    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
        $error("nmos_cmp_counter: PRESCALE must be within 2..256");
    end

`ifdef NMOS_CMP_CNT_PRESCALE_EN
    localparam int unsigned PreW = $clog2(PRESCALE);
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;

    // A count step is the CE tick that finds the prescaler at its last value.
    always_comb begin
        step = CE && (pre_q == PreLast);
    end

    // Prescaler advances only on CE in RUN; START/STOP and each step restart it.
    always_comb begin
        pre_d = pre_q;
        if (START || STOP) begin
            pre_d = '0;
        end else if (state_q == StRun && CE) begin
            if (step) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PreW'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // Without the prescaler every CE tick is a count step.
    always_comb begin
        step = CE;
    end
`endif

    // Two-stage load: LD captures the bus, C1 moves the old stage into the limit,
    // so LD and C1 together still hand the previous stage value to the limit.
    always_comb begin
        stage_d = LD ? DB : stage_q;
        limit_d = C1 ? stage_q : limit_q;
    end

    // Run-control FSM and count datapath; STOP outranks START everywhere.
    always_comb begin
        state_d = state_q;
        vv_d    = vv_q;
        tc_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START && !STOP) begin
                    state_d = StRun;
                    vv_d    = '0;
                end
            end

            StRun: begin
                if (STOP) begin
                    // Halt with VV frozen; a pending match is discarded.
                    state_d = StIdle;
                end else if (START) begin
                    vv_d = '0;
                end else if (step) begin
                    // Equality only: a limit below VV is reached after a silent wrap.
                    if (vv_q == limit_q) begin
                        tc_d = 1'b1;
                        if (ONESHOT) begin
                            state_d = StDone;
                        end else begin
                            vv_d = '0;
                        end
                    end else begin
                        vv_d = vv_q + WIDTH'(1);
                    end
                end
            end

            StDone: begin
                if (STOP) begin
                    state_d = StIdle;
                end else if (START) begin
                    state_d = StRun;
                    vv_d    = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
    end

    // State, load latches and registered outputs; reset overrides everything.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            limit_q <= '0;
            vv_q    <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            limit_q <= limit_d;
            vv_q    <= vv_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign VV   = vv_q;
    assign TC   = tc_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_nmos_cmp_counter.sv
// Scoreboard bench for nmos_cmp_counter: a driver issues one cycle of stimulus
// per clock, a behavioural model predicts VV/TC/BUSY and queues the expectation,
// and a monitor pops and compares after every rising edge.

module tb_nmos_cmp_counter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESCALE = 4;
    localparam int          MOD      = 1 << WIDTH;

    logic             main_clk;
    logic             main_rst;
    logic [WIDTH-1:0] DB;
    logic             LD, C1, CE, START, STOP, ONESHOT;
    logic [WIDTH-1:0] VV;
    logic             TC, BUSY;

    nmos_cmp_counter #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .main_clk(main_clk),
        .main_rst(main_rst),
        .DB      (DB),
        .LD      (LD),
        .C1      (C1),
        .CE      (CE),
        .START   (START),
        .STOP    (STOP),
        .ONESHOT (ONESHOT),
        .VV      (VV),
        .TC      (TC),
        .BUSY    (BUSY)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    typedef struct {
        logic [WIDTH-1:0] vv;
        logic             tc;
        logic             busy;
        string            ph;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;
    string ph = "reset";

    // Requested stimulus for the next cycle.
    logic             s_rst = 1'b1;
    logic [WIDTH-1:0] s_db  = '0;
    logic s_ld = 0, s_c1 = 0, s_ce = 0, s_start = 0, s_stop = 0, s_oneshot = 0;

    // Reference model: counter behaviour stated as plain integer arithmetic.
    int m_stage = 0, m_limit = 0, m_vv = 0, m_pre = 0;
    bit m_running = 0, m_tc = 0;

    task automatic model_step();
        int  old_stage;
        bit  was_running;
        bit  counts;
        old_stage   = m_stage;
        was_running = m_running;
        m_tc        = 0;
        if (s_rst) begin
            m_stage = 0; m_limit = 0; m_vv = 0; m_pre = 0; m_running = 0;
            return;
        end
        counts = s_ce && was_running && !s_start && !s_stop;
`ifdef NMOS_CMP_CNT_PRESCALE_EN
        if (s_start || s_stop) m_pre = 0;
        else if (was_running && s_ce) begin
            if (m_pre == PRESCALE - 1) m_pre = 0;
            else begin
                m_pre  = m_pre + 1;
                counts = 0;
            end
        end
`endif
        if (s_stop) m_running = 0;
        else if (s_start) begin
            m_running = 1;
            m_vv      = 0;
        end else if (counts) begin
            if (m_vv == m_limit) begin
                m_tc = 1;
                if (s_oneshot) m_running = 0;
                else m_vv = 0;
            end else begin
                m_vv = (m_vv + 1) % MOD;
            end
        end
        if (s_c1) m_limit = old_stage;
        if (s_ld) m_stage = int'(s_db);
    endtask

    // Drive one cycle on the falling edge and queue the predicted response.
    task automatic tick();
        exp_t e;
        @(negedge main_clk);
        main_rst = s_rst; DB = s_db; LD = s_ld; C1 = s_c1; CE = s_ce;
        START = s_start; STOP = s_stop; ONESHOT = s_oneshot;
        model_step();
        e.vv   = m_vv[WIDTH-1:0];
        e.tc   = m_tc;
        e.busy = m_running;
        e.ph   = ph;
        e.cyc  = n_cyc;
        exp_q.push_back(e);
        n_cyc++;
    endtask

    task automatic load_limit(input int val);
        s_db = WIDTH'(val); s_ld = 1; tick();
        s_ld = 0; s_c1 = 1; tick();
        s_c1 = 0;
    endtask

    task automatic start_run();
        s_start = 1; tick();
        s_start = 0;
    endtask

    task automatic run_ce(input int n);
        s_ce = 1;
        repeat (n) tick();
        s_ce = 0;
    endtask

    // Monitor: the DUT presents VV/TC/BUSY every cycle.
    exp_t got;
    initial begin
        forever begin
            @(posedge main_clk);
            #1;
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                n_tests++;
                if (VV !== got.vv || TC !== got.tc || BUSY !== got.busy) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d: got VV=%h TC=%b BUSY=%b, want VV=%h TC=%b BUSY=%b",
                             got.ph, got.cyc, VV, TC, BUSY, got.vv, got.tc, got.busy);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        main_rst = 1'b1; DB = '0; LD = 0; C1 = 0; CE = 0;
        START = 0; STOP = 0; ONESHOT = 0;

        ph = "reset";
        s_ce = 1; s_start = 1;
        repeat (2) tick();
        s_ce = 0; s_start = 0; s_rst = 0;
        tick();

        ph = "freerun_lim5";
        load_limit(5);
        start_run();
        run_ce(14);

        ph = "oneshot_lim3";
        s_oneshot = 1;
        load_limit(3);
        start_run();
        run_ce(8);
        start_run();
        run_ce(6);
        s_stop = 1; tick(); s_stop = 0;
        s_oneshot = 0;

        ph = "ld_c1_same";
        s_db = 8'h02; s_ld = 1; tick();
        s_db = 8'h0a; s_c1 = 1; tick();
        s_ld = 0; s_c1 = 0;
        start_run();
        run_ce(7);
        s_c1 = 1; tick(); s_c1 = 0;
        run_ce(14);

        ph = "limit_lowered";
        load_limit(8'h10);
        s_db = 8'h04; s_ld = 1; tick(); s_ld = 0;
        start_run();
        run_ce(12);
        s_c1 = 1; tick(); s_c1 = 0;
        run_ce(MOD + 8);

        ph = "rst_midrun";
        start_run();
        run_ce(7);
        s_rst = 1; tick(); s_rst = 0;
        s_start = 1; s_stop = 1; tick();
        s_start = 0; s_stop = 0;
        run_ce(3);

        ph = "stop_on_match";
        load_limit(2);
        start_run();
        run_ce(2);
        s_ce = 1; s_stop = 1; tick(); s_ce = 0; s_stop = 0;
        tick();

        ph = "limit_zero";
        load_limit(0);
        start_run();
        run_ce(5);

        ph = "limit_max";
        load_limit(MOD - 1);
        start_run();
        run_ce(MOD + 4);

        ph = "restart_in_run";
        load_limit(6);
        start_run();
        run_ce(4);
        s_ce = 1; s_start = 1; tick(); s_start = 0;
        run_ce(10);

`ifdef NMOS_CMP_CNT_PRESCALE_EN
        ph = "prescale";
        load_limit(2);
        start_run();
        run_ce(3 * PRESCALE + 4);
`endif

        ph = "random";
        for (int i = 0; i < 3000; i++) begin
            s_rst     = ($urandom_range(0, 499) == 0);
            s_ld      = ($urandom_range(0, 3) == 0);
            s_c1      = ($urandom_range(0, 5) == 0);
            s_ce      = ($urandom_range(0, 9) < 7);
            s_start   = ($urandom_range(0, 29) == 0);
            s_stop    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) s_oneshot = ~s_oneshot;
            if ($urandom_range(0, 7) == 0) s_db = WIDTH'($urandom());
            else s_db = WIDTH'($urandom_range(0, 20));
            tick();
        end
        s_rst = 0; s_ld = 0; s_c1 = 0; s_ce = 0; s_start = 0; s_stop = 0;

        repeat (2) @(posedge main_clk);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
